mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 10, giving the RAM word-address width.
REQ-002 The block SHALL have parameter DataWidth, default 32, giving the RAM data width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have ports p0_req, p0_we  input  1 each  port 0 (CPU memory stage) access request and write enable.
REQ-006 The block SHALL have ports p0_addr  input  AddrWidth and p0_wdata  input  DataWidth  port 0 address and write data.
REQ-007 The block SHALL have ports p0_gnt, p0_stall, p0_rvalid  output  1 each and p0_rdata  output  DataWidth  port 0 grant, stall, read-valid and read data.
REQ-008 The block SHALL have ports p1_req, p1_we, p1_lock  input  1 each, plus p1_addr and p1_wdata with the same widths as port 0  port 1 (loader/debug) signals.
REQ-009 The block SHALL have ports p1_gnt, p1_rvalid  output  1 each and p1_rdata  output  DataWidth  port 1 grant, read-valid and read data.
REQ-010 The block SHALL have RAM-side ports ram_we  output  1, ram_addr  output  AddrWidth, ram_w_data  output  DataWidth and ram_r_data  input  DataWidth.

Function
REQ-011 At most one of p0_gnt and p1_gnt SHALL be high in any cycle; grant is combinational, in the same cycle as the request.
REQ-012 The winner's we, addr and wdata SHALL drive ram_we, ram_addr and ram_w_data.
REQ-013 With no grant, ram_we SHALL be 0 and ram_addr/ram_w_data SHALL hold 0.
REQ-014 A granted read (we=0) SHALL set that port's rvalid high for exactly the next cycle, and no other cycle.
REQ-015 pN_rdata SHALL equal ram_r_data (synchronous RAM, 1-cycle latency); the value is defined only while pN_rvalid=1.
REQ-016 Granted writes SHALL produce no rvalid.
REQ-017 p0_stall SHALL equal p0_req AND NOT p0_gnt.
REQ-018 The FSM SHALL have two states: ARB (normal arbitration) and LOCK1 (port 1 owns the RAM).
REQ-019 The FSM SHALL move from ARB to LOCK1 when p1 is granted with p1_lock=1.
REQ-020 The FSM SHALL move from LOCK1 to ARB in the first cycle p1_lock=0, and that cycle SHALL arbitrate as ARB.
REQ-021 In LOCK1, p0_gnt SHALL be 0; p1_gnt SHALL equal p1_req.
REQ-022 In ARB with only one requester, that requester SHALL be granted.
REQ-023 In ARB, a tie SHALL be resolved as specified under Configuration.
REQ-024 Back-to-back grants on consecutive cycles SHALL be supported with no idle cycle.
REQ-025 rvalid for a read granted in the last LOCK1 cycle SHALL still be issued.

Reset
REQ-026 While rst_n=0, the FSM SHALL be in ARB.
REQ-027 While rst_n=0, p0_rvalid and p1_rvalid SHALL be 0.
REQ-028 While rst_n=0, the round-robin pointer SHALL indicate port 1 last granted.
REQ-029 While rst_n=0, p0_gnt, p1_gnt and ram_we SHALL be forced to 0 regardless of requests.
REQ-030 Reset assertion mid-read SHALL suppress the pending rvalid.

Configuration
REQ-031 With MEM_ARB_RR_EN defined, ties SHALL go to the port not granted most recently, via a 1-bit pointer updated on every grant.
REQ-032 Without MEM_ARB_RR_EN, ties SHALL always go to port 0 and no pointer register SHALL exist.
REQ-033 Both builds SHALL behave identically on ports; only the tie result differs.

Verification
REQ-034 Reset release, p0 read at addr 0x005 -> p0_gnt=1 same cycle, ram_addr=0x005, p0_rvalid=1 next cycle with p0_rdata=RAM[5].
REQ-035 Both ports request reads three consecutive cycles, RR build -> grants p0,p1,p0; fixed build -> p0,p0,p0 with p1_gnt=0 and p0_stall=0.
REQ-036 p1 write 0xDEADBEEF to 0x3FF with p1_lock=1 for 4 cycles while p0_req=1 -> p0_gnt=0 and p0_stall=1 for 4 cycles, then p0 is granted when p1_lock falls.
REQ-037 p1 write then p0 read of same address in next cycle -> p0_rdata=0xDEADBEEF, no rvalid for the write.
REQ-038 rst_n pulled low in the cycle after a granted read -> p0_rvalid stays 0, FSM in ARB, no grants while rst_n=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM, with a port-1 lock mode.
// Tie policy: fixed priority to port 0 by default; round-robin when MEM_ARB_RR_EN is defined.
module mem_arbiter #(
  parameter int AddrWidth = 10,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [AddrWidth-1:0] p0_addr,
  input  logic [DataWidth-1:0] p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_stall,
  output logic                 p0_rvalid,
  output logic [DataWidth-1:0] p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic                 p1_lock,
  input  logic [AddrWidth-1:0] p1_addr,
  input  logic [DataWidth-1:0] p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [DataWidth-1:0] p1_rdata,
  output logic                 ram_we,
  output logic [AddrWidth-1:0] ram_addr,
  output logic [DataWidth-1:0] ram_w_data,
  input  logic [DataWidth-1:0] ram_r_data
);

  typedef enum logic {ARB, LOCK1} state_e;

  state_e state_q, state_d;
  logic   p0_rvalid_q, p0_rvalid_d;
  logic   p1_rvalid_q, p1_rvalid_d;
  logic   tie_to_p0;

`ifdef MEM_ARB_RR_EN
  // High when port 1 held the most recent grant; reset makes port 0 the first tie winner.
  logic last_p1_q, last_p1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_p1_q <= 1'b1;
    end else begin
      last_p1_q <= last_p1_d;
    end
  end

  always_comb begin
    last_p1_d = last_p1_q;
    if (p1_gnt) begin
      last_p1_d = 1'b1;
    end else if (p0_gnt) begin
      last_p1_d = 1'b0;
    end
    tie_to_p0 = last_p1_q;
  end
`else
  assign tie_to_p0 = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    state_d = state_q;
    if (rst_n) begin
      if (state_q == LOCK1 && p1_lock) begin
        p1_gnt = p1_req;
      end else begin
        if (p0_req && p1_req) begin
          p0_gnt = tie_to_p0;
          p1_gnt = !tie_to_p0;
        end else begin
          p0_gnt = p0_req;
          p1_gnt = p1_req;
        end
        state_d = (p1_gnt && p1_lock) ? LOCK1 : ARB;
      end
    end
  end

  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_w_data = '0;
    if (p0_gnt) begin
      ram_we     = p0_we;
      ram_addr   = p0_addr;
      ram_w_data = p0_wdata;
    end else if (p1_gnt) begin
      ram_we     = p1_we;
      ram_addr   = p1_addr;
      ram_w_data = p1_wdata;
    end
    p0_rvalid_d = p0_gnt && !p0_we;
    p1_rvalid_d = p1_gnt && !p1_we;
  end

  assign p0_stall  = p0_req && !p0_gnt;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = ram_r_data;
  assign p1_rdata  = ram_r_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle RAM; tie expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [9:0]  p0_addr, p1_addr, ram_addr;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, ram_w_data, ram_r_data;
  logic        p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_rvalid, ram_we;
  logic [31:0] mem [0:1023];
  int          total = 0;
  int          passed = 0;
  logic [2:0]  tie_p0_seq;

  always #5 clk = ~clk;

  mem_arbiter #(.AddrWidth(10), .DataWidth(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_w_data;
    ram_r_data <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle before checking.
  task automatic cyc(input logic rst, input logic r0, input logic w0, input logic [9:0] a0,
                     input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                     input logic [9:0] a1, input logic [31:0] d1);
    @(negedge clk);
    rst_n = rst;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
`ifdef MEM_ARB_RR_EN
    tie_p0_seq = 3'b101;
`else
    tie_p0_seq = 3'b111;
`endif

    $display("step: reset with both ports requesting");
    cyc(0, 1, 1, 10'h005, 32'hAAAA5555, 1, 1, 0, 10'h006, 32'h1);
    check("rst_p0_gnt", p0_gnt, 0);
    check("rst_p1_gnt", p1_gnt, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_p0_rvalid", p0_rvalid, 0);
    check("rst_p1_rvalid", p1_rvalid, 0);

    $display("step: p1 write 0x12345678 to 0x005");
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 10'h005, 32'h12345678);
    check("p1w_gnt", p1_gnt, 1);
    check("p1w_p0_gnt", p0_gnt, 0);
    check("p1w_ram_we", ram_we, 1);
    check("p1w_ram_addr", ram_addr, 32'h005);
    check("p1w_ram_wdata", ram_w_data, 32'h12345678);

    $display("step: p0 read 0x005");
    cyc(1, 1, 0, 10'h005, 0, 0, 0, 0, 0, 0);
    check("p0r_gnt", p0_gnt, 1);
    check("p0r_p1_gnt", p1_gnt, 0);
    check("p0r_ram_addr", ram_addr, 32'h005);
    check("p0r_ram_we", ram_we, 0);
    check("p0r_stall", p0_stall, 0);
    check("p1w_no_rvalid", p1_rvalid, 0);

    $display("step: idle");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("p0r_rvalid", p0_rvalid, 1);
    check("p0r_rdata", p0_rdata, 32'h12345678);
    check("idle_ram_we", ram_we, 0);
    check("idle_ram_addr", ram_addr, 0);
    check("idle_ram_wdata", ram_w_data, 0);

    $display("step: p1 read 0x005");
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 10'h005, 0);
    check("p0_rvalid_one_cycle", p0_rvalid, 0);
    check("p1r_gnt", p1_gnt, 1);

    for (int i = 0; i < 3; i++) begin
      $display("step: tie read %0d", i);
      cyc(1, 1, 0, 10'h005, 0, 1, 0, 0, 10'h005, 0);
      check($sformatf("tie%0d_p0_gnt", i), p0_gnt, tie_p0_seq[2-i]);
      check($sformatf("tie%0d_p1_gnt", i), p1_gnt, !tie_p0_seq[2-i]);
      check($sformatf("tie%0d_p0_stall", i), p0_stall, !tie_p0_seq[2-i]);
      if (i == 0) begin
        check("p1r_rvalid", p1_rvalid, 1);
        check("p1r_rdata", p1_rdata, 32'h12345678);
      end else begin
        check($sformatf("tie%0d_p0_rvalid", i), p0_rvalid, tie_p0_seq[3-i]);
        check($sformatf("tie%0d_p1_rvalid", i), p1_rvalid, !tie_p0_seq[3-i]);
      end
    end

    $display("step: p1 locked write 0xDEADBEEF to 0x3FF");
    cyc(1, 0, 0, 0, 0, 1, 1, 1, 10'h3FF, 32'hDEADBEEF);
    check("tie_last_p0_rvalid", p0_rvalid, 1);
    check("lock_p1_gnt", p1_gnt, 1);
    check("lock_ram_we", ram_we, 1);
    check("lock_ram_addr", ram_addr, 32'h3FF);

    for (int i = 0; i < 4; i++) begin
      $display("step: locked cycle %0d with p0 waiting", i);
      cyc(1, 1, 0, 10'h3FF, 0, 1, 1, 1, 10'h3FF, 32'hDEADBEEF);
      check($sformatf("lock%0d_p0_gnt", i), p0_gnt, 0);
      check($sformatf("lock%0d_p0_stall", i), p0_stall, 1);
      check($sformatf("lock%0d_p1_gnt", i), p1_gnt, 1);
    end

    $display("step: lock released, p0 read 0x3FF");
    cyc(1, 1, 0, 10'h3FF, 0, 0, 0, 0, 0, 0);
    check("unlock_p0_gnt", p0_gnt, 1);
    check("unlock_p0_stall", p0_stall, 0);
    check("unlock_ram_addr", ram_addr, 32'h3FF);
    check("lockw_no_rvalid", p1_rvalid, 0);

    $display("step: idle after locked read");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("raw_p0_rvalid", p0_rvalid, 1);
    check("raw_p0_rdata", p0_rdata, 32'hDEADBEEF);

    $display("step: p0 read, then reset");
    cyc(1, 1, 0, 10'h005, 0, 0, 0, 0, 0, 0);
    check("pre_rst_p0_gnt", p0_gnt, 1);
    cyc(0, 1, 1, 10'h005, 0, 1, 0, 0, 10'h005, 0);
    check("midrst_p0_rvalid", p0_rvalid, 0);
    check("midrst_p0_gnt", p0_gnt, 0);
    check("midrst_p1_gnt", p1_gnt, 0);
    check("midrst_ram_we", ram_we, 0);
    cyc(0, 1, 1, 10'h005, 0, 1, 0, 0, 10'h005, 0);
    check("midrst2_p0_rvalid", p0_rvalid, 0);

    $display("step: p1 locked read, then reset");
    cyc(1, 0, 0, 0, 0, 1, 0, 1, 10'h005, 0);
    check("lockr_p1_gnt", p1_gnt, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 10'h005, 0);
    check("lockrst_p1_rvalid", p1_rvalid, 0);
    cyc(1, 1, 0, 10'h005, 0, 0, 0, 1, 0, 0);
    check("post_rst_arb_p0_gnt", p0_gnt, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst_p0_rvalid", p0_rvalid, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
